wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_pkg.sv | 33 +++
 rtl/wb_port_arbiter_rr_pick.sv | 30 +++
 rtl/wb_port_arbiter.sv | 102 ++++++++++
 tb/tb_wb_port_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the 4-port write-data arbiter.
// One-hot constants follow the select encoding of the shared Mux4.
package wb_port_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned PTR_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [NUM_REQ-1:0] ONEHOT_NONE = 4'b0000;
  localparam logic [NUM_REQ-1:0] ONEHOT_0    = 4'b0001;
  localparam logic [NUM_REQ-1:0] ONEHOT_1    = 4'b0010;
  localparam logic [NUM_REQ-1:0] ONEHOT_2    = 4'b0100;
  localparam logic [NUM_REQ-1:0] ONEHOT_3    = 4'b1000;

  // Index of the active bit of a one-hot select; zero when idle.
  function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    case (oh)
      ONEHOT_1: idx = PTR_W'(1);
      ONEHOT_2: idx = PTR_W'(2);
      ONEHOT_3: idx = PTR_W'(3);
      ONEHOT_0: idx = PTR_W'(0);
      default:  idx = '0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick.sv
// Round-robin picker: first unmasked requester at or above ptr (mod 4).
// Purely combinational; returns a one-hot winner and a valid flag.
module rr_pick
  import wb_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               valid_o
);

  logic [NUM_REQ-1:0] eff_c;
  logic [PTR_W-1:0]   idx_c;

  always_comb begin
    eff_c   = req_i & ~mask_i;
    win_o   = ONEHOT_NONE;
    valid_o = 1'b0;
    idx_c   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_c = PTR_W'(ptr_i + PTR_W'(i));
      if (!valid_o && eff_c[idx_c]) begin
        win_o[idx_c] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter driving a shared 4-input write-data mux and the
// destination register load enable, with bounded lock-based grant holding.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  output logic [NUM_REQ-1:0] sel,
  output logic               load_en,
  output logic [NUM_REQ-1:0] ack,
  output logic               busy
);

  localparam int unsigned        HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e             state_q;
  logic [NUM_REQ-1:0] sel_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               load_en_q;
  logic               busy_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [HOLD_W-1:0]  hold_q;

  logic [PTR_W-1:0]   g_c;
  logic [PTR_W-1:0]   ptr_d;
  logic [PTR_W-1:0]   pick_ptr_c;
  logic [NUM_REQ-1:0] mask_c;
  logic [NUM_REQ-1:0] win_c;
  logic               valid_c;
  logic               keep_c;

  // On release the next winner is picked from g+1 with g masked out.
  always_comb begin
    g_c        = onehot_idx(sel_q);
    ptr_d      = PTR_W'(g_c + PTR_W'(1));
    keep_c     = (state_q == ST_GRANT) && ((req & lock & sel_q) != ONEHOT_NONE) &&
                 (hold_q < HOLD_LAST);
    mask_c     = (state_q == ST_GRANT) ? sel_q : ONEHOT_NONE;
    pick_ptr_c = (state_q == ST_GRANT) ? ptr_d : ptr_q;
  end

  rr_pick u_pick (
    .req_i   (req),
    .mask_i  (mask_c),
    .ptr_i   (pick_ptr_c),
    .win_o   (win_c),
    .valid_o (valid_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= ONEHOT_NONE;
      ack_q     <= ONEHOT_NONE;
      load_en_q <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_c) begin
            state_q   <= ST_GRANT;
            sel_q     <= win_c;
            ack_q     <= win_c;
            load_en_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (keep_c) begin
            hold_q <= HOLD_W'(hold_q + HOLD_W'(1));
          end else begin
            ptr_q  <= ptr_d;
            hold_q <= '0;
            if (valid_c) begin
              sel_q <= win_c;
              ack_q <= win_c;
            end else begin
              state_q   <= ST_IDLE;
              sel_q     <= ONEHOT_NONE;
              ack_q     <= ONEHOT_NONE;
              load_en_q <= 1'b0;
              busy_q    <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign sel     = sel_q;
  assign ack     = ack_q;
  assign load_en = load_en_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: MAX_HOLD=4 instance plus a
// MAX_HOLD=2 instance for the lone-lock release case.
module tb_wb_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0, lock = '0;
  logic [3:0] req2 = '0, lock2 = '0;
  logic [3:0] sel, ack, sel2, ack2;
  logic       load_en, busy, load_en2, busy2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .sel(sel), .load_en(load_en), .ack(ack), .busy(busy)
  );

  wb_port_arbiter #(.MAX_HOLD(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .lock(lock2),
    .sel(sel2), .load_en(load_en2), .ack(ack2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Full output vector {busy, load_en, ack, sel} implied by an expected select.
  task automatic exp_out(input string tag, input logic [3:0] e);
    chk(tag, 32'({busy, load_en, ack, sel}), 32'({|e, |e, e, e}));
  endtask

  task automatic exp_out2(input string tag, input logic [3:0] e);
    chk(tag, 32'({busy2, load_en2, ack2, sel2}), 32'({|e, |e, e, e}));
  endtask

  task automatic inv_chk();
    chk("sel_onehot0", 32'($onehot0(sel)), 32'd1);
    chk("ack_rule", 32'(ack), load_en ? 32'(sel) : 32'd0);
    chk("sel2_onehot0", 32'($onehot0(sel2)), 32'd1);
    chk("ack2_rule", 32'(ack2), load_en2 ? 32'(sel2) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    inv_chk();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0; lock = '0; req2 = '0; lock2 = '0;
    tick();
    tick();
    exp_out("reset_state", 4'b0000);
    exp_out2("reset_state2", 4'b0000);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single requester, 1-cycle latency, then idle once it drops.
    req = 4'b0100;
    tick(); exp_out("single_grant", 4'b0100);
    req = 4'b0000;
    tick(); exp_out("single_idle", 4'b0000);
    tick(); exp_out("idle_stays", 4'b0000);

    // Lock bits of non-granted requesters are ignored; req0 re-granted after a bubble.
    req = 4'b0001; lock = 4'b1110;
    tick(); exp_out("nolock_grant", 4'b0001);
    tick(); exp_out("nolock_release", 4'b0000);
    tick(); exp_out("nolock_regrant", 4'b0001);
    req = '0; lock = '0;
    tick(); exp_out("nolock_idle", 4'b0000);

    // All four request; back-to-back grants 0..3, no bubbles.
    do_reset();
    req = 4'b1111;
    tick(); exp_out("all_g0", 4'b0001); req[0] = 1'b0;
    tick(); exp_out("all_g1", 4'b0010); req[1] = 1'b0;
    tick(); exp_out("all_g2", 4'b0100); req[2] = 1'b0;
    tick(); exp_out("all_g3", 4'b1000); req[3] = 1'b0;
    tick(); exp_out("all_idle", 4'b0000);
    // Pointer wrapped back to 0, so requester 0 leads again.
    req = 4'b1111;
    tick(); exp_out("ptr_wrap", 4'b0001);
    req = '0;
    tick(); exp_out("ptr_wrap_idle", 4'b0000);

    // Lock cap at MAX_HOLD=4: four acks to 1, then 2, then back to 1.
    do_reset();
    req = 4'b0110; lock = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick(); exp_out($sformatf("lock_hold%0d", i), 4'b0010);
    end
    tick(); exp_out("lock_cap_to2", 4'b0100);
    req[2] = 1'b0;
    tick(); exp_out("lock_back_to1", 4'b0010);
    req = '0; lock = '0;
    tick(); exp_out("lock_idle", 4'b0000);

    // Lone lock at MAX_HOLD=2: ack, ack, one idle cycle, ack.
    do_reset();
    req2 = 4'b1000; lock2 = 4'b1000;
    tick(); exp_out2("lone_ack0", 4'b1000);
    tick(); exp_out2("lone_ack1", 4'b1000);
    tick(); exp_out2("lone_bubble", 4'b0000);
    tick(); exp_out2("lone_regrant", 4'b1000);
    req2 = '0; lock2 = '0;
    tick(); exp_out2("lone_idle", 4'b0000);

    // Asynchronous reset mid-grant.
    req = 4'b0010;
    tick(); exp_out("pre_reset_grant", 4'b0010);
    reset = 1'b1;
    #2;
    exp_out("async_reset", 4'b0000);
    req = 4'b1010;
    tick(); exp_out("reset_held", 4'b0000);
    reset = 1'b0;
    tick(); exp_out("post_reset_win1", 4'b0010);
    req[1] = 1'b0;
    tick(); exp_out("post_reset_next3", 4'b1000);
    req = '0;
    tick(); exp_out("final_idle", 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
